screen_sequencer: RTL and testbench
===================================

SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

Interface
REQ-001 SHALL have parameter: NUM_SCREENS, 13, number of game screens, range 2..15.
REQ-002 SHALL have parameter: DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a button level change is accepted, at least 1.
REQ-003 SHALL have parameter: TIMEOUT_CYCLES, 1000, idle cycles before auto-advance; 0 disables auto-advance.
REQ-004 SHALL have parameter: VOL_THRESH, 12, volume level counted as a "shout", range 1..31.
REQ-005 SHALL have port: clk  input  1  single clock for all state.
REQ-006 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port: sw  input  1  game enable; low forces IDLE.
REQ-008 SHALL have port: btnR  input  1  raw next-screen button.
REQ-009 SHALL have port: btnL  input  1  raw previous-screen button.
REQ-010 SHALL have port: volume  input  5  current mic volume level.
REQ-011 SHALL have port: screen_idx  output  4  registered; 0 = idle/black, 1..NUM_SCREENS = active screen.
REQ-012 SHALL have port: active  output  1  registered; high when screen_idx is nonzero.
REQ-013 SHALL have port: screen_changed  output  1  registered one-cycle pulse on every screen_idx change.

Function
REQ-014 SHALL debounce btnR and btnL independently: each filtered level flips at the edge on which the raw input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the counter.
REQ-015 SHALL produce an internal registered press pulse for each button in the cycle after its filtered level rises 0->1; falling edges SHALL produce nothing.
REQ-016 SHALL produce an internal shout pulse for one cycle when volume >= VOL_THRESH and the previous cycle's volume was < VOL_THRESH.
REQ-017 SHALL implement two states, IDLE and SHOW.
REQ-018 IDLE: screen_idx = 0; sw high -> SHOW with screen_idx = 1 at the next edge.
REQ-019 SHOW, priority order per cycle: (a) sw low -> IDLE; (b) R and L press together -> no change; (c) R press -> next; (d) L press -> previous; (e) shout -> next; (f) timeout -> next.
REQ-020 Next SHALL wrap from NUM_SCREENS to 1, and previous SHALL wrap from 1 to NUM_SCREENS.
REQ-021 screen_idx SHALL update at the edge following the press, shout or timeout pulse, giving 1 cycle of latency.
REQ-022 The timeout counter SHALL count SHOW cycles, clear on every screen change and in IDLE, and fire when it reaches TIMEOUT_CYCLES-1; it SHALL be inert when TIMEOUT_CYCLES = 0.
REQ-023 The timeout counter SHALL be sized for TIMEOUT_CYCLES and SHALL never wrap silently.
REQ-024 screen_changed SHALL assert in the same cycle that the new screen_idx value is first visible, including IDLE<->SHOW transitions.
REQ-025 Presses, shouts and timeouts arriving in IDLE SHALL be discarded and not queued.
REQ-026 A button already held when sw rises SHALL NOT cause an advance until it is released and pressed again.

Reset
REQ-027 reset high at an edge SHALL set: state IDLE, screen_idx 0, active 0, screen_changed 0, filtered levels 0, and all counters and pulses 0.
REQ-028 reset SHALL take priority over all other inputs; asserting it mid-debounce or mid-timeout SHALL discard the progress.
REQ-029 Behaviour after reset SHALL depend only on inputs sampled after reset deasserts.

Verification
REQ-030 Bench: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=0, NUM_SCREENS=13. Raise sw -> next edge: screen_idx=1, active=1, screen_changed=1 for 1 cycle.
REQ-031 Bench: btnR high for 3 cycles, then low -> screen_idx stays 1. btnR high for 4+ cycles -> screen_idx=2, exactly 4+2 edges after btnR rose, with a single screen_changed pulse.
REQ-032 Bench: from screen 13, press R -> 1. From 1, press L -> 13. R and L filtered in the same cycle -> no change and no pulse.
REQ-033 Bench: TIMEOUT_CYCLES=10 with no input -> screen advances every 10 cycles. A press at cycle 7 advances once and restarts the 10-cycle count.
REQ-034 Bench: volume steps 5->20 -> one advance. Holding 20 causes no further advance. 20->5->20 -> a second advance.
REQ-035 Bench: sw low mid-debounce -> IDLE, screen_idx=0 next edge. reset mid-SHOW -> all outputs 0 next edge. Holding btnR while sw rises -> screen_idx stays 1.

Source files
------------

// File: rtl/screen_sequencer_if.sv
// Bus between the game controls and the screen sequencer.
// master drives sw/btnR/btnL/volume and reads the screen outputs; slave is the sequencer.
interface screen_sequencer_if;
    logic       sw;
    logic       btnR;
    logic       btnL;
    logic [4:0] volume;
    logic [3:0] screen_idx;
    logic       active;
    logic       screen_changed;

    modport master (
        output sw, btnR, btnL, volume,
        input  screen_idx, active, screen_changed
    );

    modport slave (
        input  sw, btnR, btnL, volume,
        output screen_idx, active, screen_changed
    );
endinterface

// File: rtl/screen_sequencer.sv
// Steps through game screens on button presses, shouts into the mic or idle timeout.
// Ports: clk, reset (sync, active high), bus (slave): sw/btnR/btnL/volume in,
// screen_idx/active/screen_changed out (all outputs registered).
module screen_sequencer #(
    parameter int NUM_SCREENS     = 13,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int VOL_THRESH      = 12
) (
    input logic               clk,
    input logic               reset,
    screen_sequencer_if.slave bus
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLAST =
        (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    // bit 0 = right button, bit 1 = left button
    logic [1:0]         raw;
    logic [1:0]         filt;
    logic [1:0]         filt_d;
    logic [1:0]         press;
    logic [1:0][DW-1:0] dcnt;

    logic vol_hi;
    logic vol_hi_d;
    logic shout;

    state_t        state;
    state_t        state_nx;
    logic [3:0]    idx;
    logic [3:0]    idx_nx;
    logic [3:0]    idx_inc;
    logic [3:0]    idx_dec;
    logic          active;
    logic          changed;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_nx;
    logic          tmo;

    assign raw    = {bus.btnL, bus.btnR};
    assign vol_hi = bus.volume >= 5'(VOL_THRESH);

    // Debounce: the counter tracks how long raw has disagreed with the
    // filtered level; the flip lands on the DEBOUNCE_CYCLES-th disagreement.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt     <= '0;
            filt_d   <= '0;
            press    <= '0;
            dcnt     <= '0;
            vol_hi_d <= 1'b0;
            shout    <= 1'b0;
        end else begin
            filt_d   <= filt;
            press    <= filt & ~filt_d;
            vol_hi_d <= vol_hi;
            shout    <= vol_hi & ~vol_hi_d;
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == filt[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DLAST) begin
                    filt[i] <= raw[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    assign idx_inc = (idx == 4'(NUM_SCREENS)) ? 4'd1 : idx + 4'd1;
    assign idx_dec = (idx == 4'd1) ? 4'(NUM_SCREENS) : idx - 4'd1;

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        tmo      = (TIMEOUT_CYCLES > 0) && (tcnt == TLAST);
        unique case (state)
            IDLE: begin
                if (bus.sw) begin
                    state_nx = SHOW;
                    idx_nx   = 4'd1;
                end
            end
            SHOW: begin
                if (!bus.sw) begin
                    state_nx = IDLE;
                    idx_nx   = 4'd0;
                end else if (press[0] && press[1]) begin
                    idx_nx = idx;
                end else if (press[0]) begin
                    idx_nx = idx_inc;
                end else if (press[1]) begin
                    idx_nx = idx_dec;
                end else if (shout || tmo) begin
                    idx_nx = idx_inc;
                end
            end
        endcase

        // A two-button cancel can block a due timeout; hold the count at
        // its last value so the timeout fires on the next free cycle.
        if (TIMEOUT_CYCLES == 0 || state_nx != SHOW || idx_nx != idx) begin
            tcnt_nx = '0;
        end else if (tcnt == TLAST) begin
            tcnt_nx = tcnt;
        end else begin
            tcnt_nx = tcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            active  <= 1'b0;
            changed <= 1'b0;
            tcnt    <= '0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            active  <= idx_nx != 4'd0;
            changed <= idx_nx != idx;
            tcnt    <= tcnt_nx;
        end
    end

    assign bus.screen_idx     = idx;
    assign bus.active         = active;
    assign bus.screen_changed = changed;

endmodule

// File: tb/tb_screen_sequencer.sv
// Bench for screen_sequencer: directed scenarios plus a randomized run
// checked against a rule-level model; two DUTs, timeout off and timeout 10.
module tb_screen_sequencer;

    localparam int D  = 4;
    localparam int N  = 13;
    localparam int VT = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic       sw;
    logic       btnR;
    logic       btnL;
    logic [4:0] volume;

    int total = 0;
    int bad   = 0;

    screen_sequencer_if if0 ();
    screen_sequencer_if if1 ();

    assign if0.sw = sw;
    assign if0.btnR = btnR;
    assign if0.btnL = btnL;
    assign if0.volume = volume;
    assign if1.sw = sw;
    assign if1.btnR = btnR;
    assign if1.btnL = btnL;
    assign if1.volume = volume;

    screen_sequencer #(
        .NUM_SCREENS(N), .DEBOUNCE_CYCLES(D),
        .TIMEOUT_CYCLES(0), .VOL_THRESH(VT)
    ) dut0 (.clk(clk), .reset(reset), .bus(if0));

    screen_sequencer #(
        .NUM_SCREENS(N), .DEBOUNCE_CYCLES(D),
        .TIMEOUT_CYCLES(10), .VOL_THRESH(VT)
    ) dut1 (.clk(clk), .reset(reset), .bus(if1));

    always #5 clk = ~clk;

    // Reference model: rules stated per sampled clock edge.
    int   to_cfg [2] = '{0, 10};
    bit   qr[$];
    bit   ql[$];
    logic m_fr, m_fl;
    int   run_r, run_l;
    logic vh1, vh2;
    logic [3:0] m_scr [2];
    logic       m_chg [2];
    int         m_since [2];

    always @(posedge clk) begin
        bit pr, pl, sh, rise_r, rise_l;
        logic [3:0] cur, nx;
        if (reset) begin
            qr.delete(); qr.push_back(0); qr.push_back(0);
            ql.delete(); ql.push_back(0); ql.push_back(0);
            m_fr = 0; m_fl = 0; run_r = 0; run_l = 0;
            vh1 = 0; vh2 = 0;
            for (int k = 0; k < 2; k++) begin
                m_scr[k] = 0; m_chg[k] = 0; m_since[k] = 0;
            end
        end else begin
            // a filtered rise acts on the screen two edges later
            pr = qr.pop_front();
            pl = ql.pop_front();
            sh = vh1 && !vh2;
            rise_r = 0;
            rise_l = 0;
            if (btnR !== m_fr) run_r++; else run_r = 0;
            if (run_r == D) begin m_fr = btnR; run_r = 0; rise_r = m_fr; end
            if (btnL !== m_fl) run_l++; else run_l = 0;
            if (run_l == D) begin m_fl = btnL; run_l = 0; rise_l = m_fl; end
            qr.push_back(rise_r);
            ql.push_back(rise_l);
            vh2 = vh1;
            vh1 = (volume >= VT);
            for (int k = 0; k < 2; k++) begin
                cur = m_scr[k];
                nx  = cur;
                if (cur == 0) begin
                    if (sw) nx = 1;
                end else if (!sw) nx = 0;
                else if (pr && pl) nx = cur;
                else if (pr) nx = 4'(cur % N + 1);
                else if (pl) nx = 4'((cur + N - 2) % N + 1);
                else if (sh) nx = 4'(cur % N + 1);
                else if (to_cfg[k] != 0 && m_since[k] + 1 >= to_cfg[k])
                    nx = 4'(cur % N + 1);
                m_chg[k]   = (nx != cur);
                m_since[k] = (nx != cur || nx == 0) ? 0 : m_since[k] + 1;
                m_scr[k]   = nx;
            end
        end
    end

    task automatic do_reset();
        reset = 1; sw = 0; btnR = 0; btnL = 0; volume = 0;
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    task automatic press(input logic r, input logic l);
        btnR = r; btnL = l;
        repeat (D + 1) @(negedge clk);
        btnR = 0; btnL = 0;
        repeat (D + 2) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [5:0] got;
        reset = 1; sw = 1; btnR = 1; btnL = 0; volume = 20;
        repeat (3) @(negedge clk);
        got = {if0.screen_idx, if0.active, if0.screen_changed};
        total++;
        if (got !== 6'd0) begin
            bad++; $display("FAIL reset_dut0 got=%h want=00", got);
        end
        got = {if1.screen_idx, if1.active, if1.screen_changed};
        total++;
        if (got !== 6'd0) begin
            bad++; $display("FAIL reset_dut1 got=%h want=00", got);
        end
        reset = 0; sw = 0; btnR = 0; volume = 0;
        @(negedge clk);
    endtask

    task automatic test_enable();
        logic [5:0] got;
        sw = 1;
        @(negedge clk);
        got = {if0.screen_idx, if0.active, if0.screen_changed};
        total++;
        if (got !== {4'd1, 1'b1, 1'b1}) begin
            bad++; $display("FAIL enable got=%h want=07", got);
        end
        @(negedge clk);
        got = {if0.screen_idx, if0.active, if0.screen_changed};
        total++;
        if (got !== {4'd1, 1'b1, 1'b0}) begin
            bad++; $display("FAIL enable_pulse got=%h want=06", got);
        end
    endtask

    task automatic test_debounce();
        logic [5:0] got, want;
        btnR = 1;
        repeat (D - 1) @(negedge clk);
        btnR = 0;
        repeat (6) @(negedge clk);
        got = {if0.screen_idx, if0.active, if0.screen_changed};
        total++;
        if (got !== {4'd1, 1'b1, 1'b0}) begin
            bad++; $display("FAIL glitch got=%h want=06", got);
        end
        btnR = 1;
        for (int i = 1; i <= D + 3; i++) begin
            @(negedge clk);
            if (i < D + 2) want = {4'd1, 1'b1, 1'b0};
            else if (i == D + 2) want = {4'd2, 1'b1, 1'b1};
            else want = {4'd2, 1'b1, 1'b0};
            got = {if0.screen_idx, if0.active, if0.screen_changed};
            total++;
            if (got !== want) begin
                bad++; $display("FAIL debounce_c%0d got=%h want=%h", i, got, want);
            end
        end
        btnR = 0;
        repeat (D + 3) @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [5:0] got;
        press(0, 1);
        press(0, 1);
        total++;
        if (if0.screen_idx !== 4'd13) begin
            bad++; $display("FAIL wrap_prev got=%0d want=13", if0.screen_idx);
        end
        press(1, 0);
        total++;
        if (if0.screen_idx !== 4'd1) begin
            bad++; $display("FAIL wrap_next got=%0d want=1", if0.screen_idx);
        end
        btnR = 1; btnL = 1;
        for (int i = 1; i <= D + 4; i++) begin
            @(negedge clk);
            got = {if0.screen_idx, if0.active, if0.screen_changed};
            total++;
            if (got !== {4'd1, 1'b1, 1'b0}) begin
                bad++; $display("FAIL both_c%0d got=%h want=06", i, got);
            end
        end
        btnR = 0; btnL = 0;
        repeat (D + 2) @(negedge clk);
    endtask

    task automatic test_timeout();
        logic [5:0] got, want;
        int e;
        do_reset();
        sw = 1;
        @(negedge clk);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            want = {4'(1 + i / 10), 1'b1, (i % 10 == 0)};
            got = {if1.screen_idx, if1.active, if1.screen_changed};
            total++;
            if (got !== want) begin
                bad++; $display("FAIL tmo_c%0d got=%h want=%h", i, got, want);
            end
        end
        for (int j = 1; j <= 27; j++) begin
            @(negedge clk);
            e = 3 + int'(j >= 7) + int'(j >= 17) + int'(j >= 27);
            want = {4'(e), 1'b1, (j == 7 || j == 17 || j == 27)};
            got = {if1.screen_idx, if1.active, if1.screen_changed};
            total++;
            if (got !== want) begin
                bad++; $display("FAIL tmo_press_c%0d got=%h want=%h", j, got, want);
            end
            if (j == 1) btnR = 1;
            if (j == 5) btnR = 0;
        end
    endtask

    task automatic test_shout();
        logic [5:0] got, want;
        do_reset();
        volume = 5; sw = 1;
        repeat (3) @(negedge clk);
        volume = 20;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            want = {(i < 2) ? 4'd1 : 4'd2, 1'b1, (i == 2)};
            got = {if0.screen_idx, if0.active, if0.screen_changed};
            total++;
            if (got !== want) begin
                bad++; $display("FAIL shout_c%0d got=%h want=%h", i, got, want);
            end
        end
        volume = 5;
        repeat (2) @(negedge clk);
        volume = 20;
        repeat (3) @(negedge clk);
        got = {if0.screen_idx, if0.active, if0.screen_changed};
        total++;
        if (got !== {4'd3, 1'b1, 1'b0}) begin
            bad++; $display("FAIL shout_again got=%h want=0e", got);
        end
        volume = 0;
    endtask

    task automatic test_sw_reset();
        logic [5:0] got;
        btnR = 1;
        repeat (2) @(negedge clk);
        sw = 0;
        @(negedge clk);
        got = {if0.screen_idx, if0.active, if0.screen_changed};
        total++;
        if (got !== 6'b000001) begin
            bad++; $display("FAIL sw_off got=%h want=01", got);
        end
        repeat (D + 4) @(negedge clk);
        sw = 1;
        repeat (10) @(negedge clk);
        got = {if0.screen_idx, if0.active, if0.screen_changed};
        total++;
        if (got !== {4'd1, 1'b1, 1'b0}) begin
            bad++; $display("FAIL held_btn got=%h want=06", got);
        end
        btnR = 0;
        repeat (D + 2) @(negedge clk);
        press(1, 0);
        total++;
        if (if0.screen_idx !== 4'd2) begin
            bad++; $display("FAIL pre_reset got=%0d want=2", if0.screen_idx);
        end
        reset = 1;
        @(negedge clk);
        got = {if0.screen_idx, if0.active, if0.screen_changed};
        total++;
        if (got !== 6'd0) begin
            bad++; $display("FAIL reset_show0 got=%h want=00", got);
        end
        got = {if1.screen_idx, if1.active, if1.screen_changed};
        total++;
        if (got !== 6'd0) begin
            bad++; $display("FAIL reset_show1 got=%h want=00", got);
        end
        reset = 0;
        @(negedge clk);
        btnR = 1;
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        repeat (2) @(negedge clk);
        btnR = 0;
        repeat (10) @(negedge clk);
        total++;
        if (if0.screen_idx !== 4'd1) begin
            bad++; $display("FAIL reset_debounce got=%0d want=1", if0.screen_idx);
        end
    endtask

    task automatic test_random();
        logic [5:0] got, want;
        do_reset();
        sw = 1;
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            want = {m_scr[0], m_scr[0] != 4'd0, m_chg[0]};
            got = {if0.screen_idx, if0.active, if0.screen_changed};
            total++;
            if (got !== want) begin
                bad++; $display("FAIL rand0_c%0d got=%h want=%h", n, got, want);
            end
            want = {m_scr[1], m_scr[1] != 4'd0, m_chg[1]};
            got = {if1.screen_idx, if1.active, if1.screen_changed};
            total++;
            if (got !== want) begin
                bad++; $display("FAIL rand1_c%0d got=%h want=%h", n, got, want);
            end
            if ($urandom % 8 == 0) btnR = ~btnR;
            if ($urandom % 8 == 0) btnL = ~btnL;
            if ($urandom % 5 == 0) volume = 5'($urandom % 32);
            if ($urandom % 100 == 0) sw = ~sw;
            reset = ($urandom % 300 == 0);
        end
        reset = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_enable();
        test_debounce();
        test_wrap();
        test_timeout();
        test_shout();
        test_sw_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
